// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the I/D memory-port arbiter:
//   - default block address / block data widths
//   - port identifiers used for grants and for the last-served record
//   - arbiter state encoding
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// One block-transfer memory port. The same bundle is used for the I-cache
// port, the D-cache port and the external memory port.
//   read  : block read request / strobe       (requester -> responder)
//   write : block write request / strobe      (requester -> responder)
//   addr  : block address                     (requester -> responder)
//   wdata : block write data                  (requester -> responder)
//   rdata : block read data                   (responder -> requester)
//   ready : one-cycle completion pulse        (responder -> requester)
// Modports:
//   master : requester side (cache, or the arbiter toward memory)
//   slave  : responder side (arbiter toward a cache, or the memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output read,
        output write,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick.
//   req_i : I-cache request
//   req_d : D-cache request
//   last  : port served most recently (PORT_I / PORT_D)
//   any   : at least one request present
//   gnt   : port to grant (only meaningful when any = 1)
// On a tie the port that was not served last wins.
// ---------------------------------------------------------------------------
module rr_pick2
    import mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic any,
    output logic gnt
);

    always_comb begin
        any = req_i | req_d;
        gnt = PORT_I;
        if (req_i && req_d) begin
            gnt = ~last;
        end else if (req_d) begin
            gnt = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one block-wide memory port between the I-cache and the D-cache.
// Whole block transfers are serialised; the memory strobes, address and
// write data are registered; completion is routed to the owning cache only.
// Ports:
//   clk        : rising-edge clock
//   proc_reset : asynchronous, active-high reset
//   i_mem      : I-cache port (slave)  - read requests only
//   d_mem      : D-cache port (slave)  - read and write-back requests
//   mem        : external memory port (master)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  i_mem,
    mem_arbiter_if.slave  d_mem,
    mem_arbiter_if.master mem
);

    state_t            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_r, rdata_d;
    logic              last_r, last_d;

    logic              i_req, d_req;
    logic              gnt_any, gnt_id;
    logic [DATA_W-1:0] rdata_out;

    assign i_req = i_mem.read;
    assign d_req = d_mem.read | d_mem.write;

    rr_pick2 u_pick (
        .req_i (i_req),
        .req_d (d_req),
        .last  (last_r),
        .any   (gnt_any),
        .gnt   (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_d      = last_r;
        // Captured regardless of state so a late consumer always sees the
        // most recent memory data.
        rdata_d     = mem.ready ? mem.rdata : rdata_r;

        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    last_d = gnt_id;
                    if (gnt_id == PORT_D) begin
                        state_d     = S_GRANT_D;
                        mem_addr_d  = d_mem.addr;
                        mem_wdata_d = d_mem.wdata;
                        // A simultaneous read+write is split: the write-back
                        // goes first, the read stays pending for a later grant.
                        mem_write_d = d_mem.write;
                        mem_read_d  = ~d_mem.write;
                    end else begin
                        state_d     = S_GRANT_I;
                        mem_addr_d  = i_mem.addr;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (mem.ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_RELEASE;
                end
            end
            // The served cache may still hold its request for one cycle
            // after ready; this state swallows that stale request.
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_r     <= '0;
            last_r      <= PORT_I;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_r     <= rdata_d;
            last_r      <= last_d;
        end
    end

    assign mem.read  = mem_read_q;
    assign mem.write = mem_write_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;

    // Pass-through in the ready cycle, held copy afterwards.
    assign rdata_out   = mem.ready ? mem.rdata : rdata_r;
    assign i_mem.rdata = rdata_out;
    assign d_mem.rdata = rdata_out;

    assign i_mem.ready = (state_q == S_GRANT_I) && mem.ready;
    assign d_mem.ready = (state_q == S_GRANT_D) && mem.ready;

endmodule
